// File: rtl/sram_data_responder_pkg.sv
// Shared types and constants for the word-to-half-word SRAM responder.
// Pure definitions; no timing or flow-control behaviour of its own.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_RESP   = 2'd3
  } sram_state_t;

  localparam int   SRAM_DW      = 16;
  localparam logic STROBE_OFF   = 1'b1;
  localparam logic DQ_DRIVE_OFF = 1'b0;

  // Misaligned word, or any byte-address bit above the SRAM's reach.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic e;
    e = (addr[1:0] != 2'b00);
    for (int i = 2; i < 32; i++) begin
      if (i > aw && addr[i]) e = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/sram_data_responder_wait_counter.sv
// Half-word window timer: reloads WAIT-1 on i_load, counts down to 0 and holds.
// One-cycle load latency; no flow control.
module sram_wait_counter #(
  parameter int WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last,
  output logic o_we_window,
  output logic o_we_next
);

  localparam int            CW     = $clog2(WAIT);
  localparam logic [CW-1:0] C_LOAD = CW'(WAIT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= C_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign o_last      = (r_cnt == '0);
  assign o_we_window = (r_cnt != '0);
  // Next cycle still inside the write-enable window; lets the pin register
  // raise we_n exactly at the start of the final (data hold) cycle.
  assign o_we_next   = (r_cnt != '0) && (r_cnt != C_ONE);

endmodule

// File: rtl/sram_data_responder.sv
// Word load/store responder over a 16-bit async SRAM, two WAIT-cycle halves per word.
// Response 2*WAIT+1 cycles after accept (1 for errors); req_ready only when idle, no rsp backpressure.
module sram_data_responder
  import sram_pkg::*;
#(
  parameter int SRAM_AW = 18,
  parameter int WAIT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  sram_state_t          r_state;
  logic                 r_write;
  logic [31:0]          r_wdata;
  logic [SRAM_AW-2:0]   r_word;
  logic [SRAM_DW-1:0]   r_rdata_lo;

  logic                 w_hs;
  logic                 w_err;
  logic                 w_load;
  logic                 w_last;
  logic                 w_we_window;
  logic                 w_we_next;
  logic [SRAM_AW-2:0]   w_word;

  assign req_ready = (r_state == ST_IDLE);
  assign w_hs      = req_valid && req_ready;
  assign w_err     = addr_err(req_addr, SRAM_AW);
  assign w_word    = req_addr[SRAM_AW:2];
  assign w_load    = (w_hs && !w_err) || (r_state == ST_ACC_LO && w_last);

  sram_wait_counter #(
    .WAIT (WAIT)
  ) u_wait (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .o_last      (w_last),
    .o_we_window (w_we_window),
    .o_we_next   (w_we_next)
  );

  // Pin registers are loaded with the values for the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_word      <= '0;
      r_rdata_lo  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      sram_addr   <= '0;
      sram_ce_n   <= STROBE_OFF;
      sram_oe_n   <= STROBE_OFF;
      sram_we_n   <= STROBE_OFF;
      sram_dq_out <= '0;
      sram_dq_oe  <= DQ_DRIVE_OFF;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_err) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state     <= ST_ACC_LO;
              r_write     <= req_write;
              r_wdata     <= req_wdata;
              r_word      <= w_word;
              sram_addr   <= {w_word, 1'b0};
              sram_ce_n   <= 1'b0;
              sram_oe_n   <= req_write;
              sram_we_n   <= !req_write;
              sram_dq_oe  <= req_write;
              sram_dq_out <= req_wdata[15:0];
            end
          end
        end
        ST_ACC_LO: begin
          if (w_last) begin
            if (!r_write) r_rdata_lo <= sram_dq_in;
            r_state     <= ST_ACC_HI;
            sram_addr   <= {r_word, 1'b1};
            sram_we_n   <= !r_write;
            sram_dq_out <= r_wdata[31:16];
          end else begin
            sram_we_n <= !(r_write && w_we_next);
          end
        end
        ST_ACC_HI: begin
          if (w_last) begin
            r_state    <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_rdata  <= r_write ? 32'h0 : {sram_dq_in, r_rdata_lo};
            sram_ce_n  <= STROBE_OFF;
            sram_oe_n  <= STROBE_OFF;
            sram_we_n  <= STROBE_OFF;
            sram_dq_oe <= DQ_DRIVE_OFF;
          end else begin
            sram_we_n <= !(r_write && w_we_next);
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (rst)
    !(!sram_oe_n && !sram_we_n));
  a_we_in_window: assert property (@(posedge clk) disable iff (rst)
    (!sram_we_n |-> w_we_window));

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed bench for sram_data_responder with a small behavioural SRAM.
module tb_sram_data_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_dat = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_dat;
    else if (!sram_ce_n && !sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;
  end

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

  sram_data_responder #(.SRAM_AW(18), .WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issues one request and records pin activity until the response strobe.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic [3:0] weh, output logic [17:0] a1, output logic [17:0] a3,
                        output int ce_low, output int rdy_bad, output int bad_pin);
    int n;
    lat = 99; rd = '0; er = 1'b0; weh = 4'b1111; a1 = '0; a3 = '0;
    ce_low = 0; rdy_bad = 0; bad_pin = 0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0000_0003; req_wdata = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 4) weh[k-1] = sram_we_n;
      if (k == 1) a1 = sram_addr;
      if (k == 3) a3 = sram_addr;
      if (!sram_ce_n) ce_low++;
      if (req_ready) rdy_bad++;
      if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !wr)) bad_pin++;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      bad++; $display("FAIL reset_strobes got=%b exp=1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
    total++; if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
      bad++; $display("FAIL reset_pins got=%h/%h exp=0/0", sram_addr, sram_dq_out); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    int lat, ce_low, rdy_bad, bad_pin; logic [31:0] rd; logic er; logic [3:0] weh; logic [17:0] a1, a3;
    do_req(1'b0, 32'h80, 32'h0, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 5) begin bad++; $display("FAIL read_lat got=%0d exp=5", lat); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL read_data got=%h/%b exp=deadbeef/0", rd, er); end
    total++; if (weh !== 4'b1111 || bad_pin !== 0) begin
      bad++; $display("FAIL read_we got=%b/%0d exp=1111/0", weh, bad_pin); end
    total++; if (a1 !== 18'h40 || a3 !== 18'h41 || ce_low !== 4) begin
      bad++; $display("FAIL read_addr got=%h/%h/%0d exp=40/41/4", a1, a3, ce_low); end
    total++; if (rdy_bad !== 0) begin bad++; $display("FAIL read_ready got=%0d exp=0", rdy_bad); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b1) begin
      bad++; $display("FAIL read_hold got=%b/%h/%b exp=0/deadbeef/1", rsp_valid, rsp_rdata, req_ready); end
  endtask

  task automatic test_write_read();
    int lat, ce_low, rdy_bad, bad_pin; logic [31:0] rd; logic er; logic [3:0] weh; logic [17:0] a1, a3;
    do_req(1'b1, 32'h100, 32'h12345678, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 5 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL write_rsp got=%0d/%h/%b exp=5/0/0", lat, rd, er); end
    total++; if (weh !== 4'b1010 || bad_pin !== 0) begin
      bad++; $display("FAIL write_we got=%b/%0d exp=1010/0", weh, bad_pin); end
    total++; if (a1 !== 18'h80 || a3 !== 18'h81) begin
      bad++; $display("FAIL write_addr got=%h/%h exp=80/81", a1, a3); end
    total++; if (mem[10'h80] !== 16'h5678 || mem[10'h81] !== 16'h1234) begin
      bad++; $display("FAIL write_mem got=%h/%h exp=5678/1234", mem[10'h80], mem[10'h81]); end
    do_req(1'b0, 32'h100, 32'h0, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 5 || rd !== 32'h12345678) begin
      bad++; $display("FAIL write_readback got=%0d/%h exp=5/12345678", lat, rd); end
  endtask

  task automatic test_errors();
    int lat, ce_low, rdy_bad, bad_pin; logic [31:0] rd; logic er; logic [3:0] weh; logic [17:0] a1, a3;
    do_req(1'b0, 32'h102, 32'h0, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || ce_low !== 0) begin
      bad++; $display("FAIL misaligned got=%0d/%b/%h/%0d exp=1/1/0/0", lat, er, rd, ce_low); end
    do_req(1'b1, 32'h0008_0000, 32'hFFFF_FFFF, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || ce_low !== 0 || weh !== 4'b1111) begin
      bad++; $display("FAIL out_of_range got=%0d/%b/%h/%0d/%b exp=1/1/0/0/1111", lat, er, rd, ce_low, weh); end
    do_req(1'b0, 32'h0007_FFFC, 32'h0, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 5 || er !== 1'b0 || a1 !== 18'h3FFFE || a3 !== 18'h3FFFF) begin
      bad++; $display("FAIL top_word got=%0d/%b/%h/%h exp=5/0/3fffe/3ffff", lat, er, a1, a3); end
  endtask

  task automatic test_back_to_back();
    int n, lo, rsp_at, k2; logic [31:0] r1, r2;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    @(posedge clk); #1;
    req_addr = 32'h100;
    n = 1; lo = 0; rsp_at = 0; r1 = '0;
    while (!req_ready && n < 20) begin
      if (rsp_valid) begin rsp_at = n; r1 = rsp_rdata; end
      lo++;
      @(posedge clk); #1; n++;
    end
    total++; if (n !== 6 || lo !== 5) begin
      bad++; $display("FAIL b2b_accept got=%0d/%0d exp=6/5", n, lo); end
    total++; if (rsp_at !== 5 || r1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b2b_first got=%0d/%h exp=5/deadbeef", rsp_at, r1); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    k2 = 99; r2 = '0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin k2 = k; r2 = rsp_rdata; break; end
      @(posedge clk); #1;
    end
    total++; if (k2 !== 5 || r2 !== 32'h12345678) begin
      bad++; $display("FAIL b2b_second got=%0d/%h exp=5/12345678", k2, r2); end
  endtask

  task automatic test_reset_mid_write();
    int n, seen, lat, ce_low, rdy_bad, bad_pin; logic [31:0] rd; logic er; logic [3:0] weh; logic [17:0] a1, a3;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (sram_addr !== 18'h101 || sram_we_n !== 1'b0) begin
      bad++; $display("FAIL midwr_acc_hi got=%h/%b exp=101/0", sram_addr, sram_we_n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110 || req_ready !== 1'b1) begin
      bad++; $display("FAIL midwr_reset got=%b/%b exp=1110/1", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, req_ready); end
    total++; if (rsp_valid !== 1'b0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
      bad++; $display("FAIL midwr_pins got=%b/%h/%h exp=0/0/0", rsp_valid, sram_addr, sram_dq_out); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midwr_no_rsp got=%0d exp=0", seen); end
    do_req(1'b0, 32'h80, 32'h0, lat, rd, er, weh, a1, a3, ce_low, rdy_bad, bad_pin);
    total++; if (lat !== 5 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL midwr_recover got=%0d/%h/%b exp=5/deadbeef/0", lat, rd, er); end
  endtask

  initial begin
    #1;
    preload(10'h040, 16'hBEEF);
    preload(10'h041, 16'hDEAD);
    test_reset();
    test_read();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_data_responder.md
# sram_data_responder

Responder side of the processor's load/store memory interface. Accepts one word request at a time from the `lw`/`sw` datapath and performs the access on an external asynchronous 16-bit SRAM as two half-word cycles. Each half-word cycle lasts a programmable number of clock cycles. The block returns one response per accepted request and sits between the CPU memory stage and the board SRAM pins.

## Interface
**Parameters**
- `SRAM_AW`, default 18: SRAM half-word address width.
- `WAIT`, default 2: clocks per half-word access. Must be ≥ 2.

**Ports**
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_write`, in, 1: 1 = `sw`, 0 = `lw`.
- `req_addr`, in, 32: byte address (`$s + offset`).
- `req_wdata`, in, 32: store data (`$t`).
- `rsp_valid`, out, 1: one-cycle response strobe. No backpressure.
- `rsp_rdata`, out, 32: load data. 0 for stores and errors.
- `rsp_err`, out, 1: misaligned or out-of-range request.
- `sram_addr`, out, SRAM_AW: half-word address.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, out, 1 each: active-low strobes.
- `sram_dq_out`, out, 16: write data.
- `sram_dq_oe`, out, 1: drive enable for the data pins.
- `sram_dq_in`, in, 16: read data from the pins.

## Operation
**States:** IDLE, ACC_LO, ACC_HI, RESP.
- `req_ready` = 1 only in IDLE.
- A handshake is `req_valid && req_ready` at a rising edge.

**Error check at accept:**
- An error exists if `req_addr[1:0] != 0`, or if any of `req_addr[31:SRAM_AW+1]` is nonzero.
- On error: go straight to RESP with `rsp_err=1` and `rsp_rdata=0`. No SRAM strobe is ever asserted.

**Normal accept:**
- Latch `req_write`, `req_wdata`, and word address `W = req_addr[SRAM_AW:2]`.
- Go to ACC_LO.

**ACC_LO, WAIT cycles:**
- `sram_addr = {W,1'b0}`, `ce_n = 0`.
- Read:
  - `oe_n = 0`.
  - Latch `sram_dq_in` into `rdata[15:0]` at the edge ending the last cycle.
- Write:
  - `dq_oe = 1`, `dq_out = wdata[15:0]` for all WAIT cycles.
  - `we_n = 0` for cycles 1..WAIT−1 and high in the last cycle (data hold).
- Then go to ACC_HI.

**ACC_HI:** same as ACC_LO with `sram_addr = {W,1'b1}` and the upper half, `rdata[31:16]` / `wdata[31:16]`. Then go to RESP.

**RESP, 1 cycle:**
- `rsp_valid = 1`, all strobes inactive.
- `rsp_rdata` = assembled word for reads, 0 for writes.
- Then go to IDLE.

**Other rules:**
- `rsp_rdata`/`rsp_err` hold their value until the next RESP.
- Request inputs are ignored outside the accept cycle.

**Reset, including mid-access:**
- Next edge: state = IDLE, `req_ready = 1`, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
- `sram_ce_n`/`oe_n`/`we_n` = 1, `dq_oe = 0`, `sram_addr = 0`, `dq_out = 0`.
- No response is issued for the aborted request; a partial write is abandoned.

## Timing
- Let T be the handshake cycle.
- **Normal request:**
  - ACC_LO occupies T+1..T+WAIT.
  - ACC_HI occupies T+WAIT+1..T+2·WAIT.
  - `rsp_valid` is high in cycle T+2·WAIT+1.
  - The next accept is possible at T+2·WAIT+2 at the earliest. WAIT=2 gives a response at T+5 and a next accept at T+6.
- **Error request:** `rsp_valid` at T+1, next accept at T+2.
- All SRAM pin outputs are registered, so they are glitch-free.
- Address and `dq_out` are stable for the whole half-window, including the cycle in which `we_n` rises.
- `oe_n` and `we_n` are never low simultaneously.
- `dq_oe` is never 1 during a read.

## Structure
- Package `sram_pkg`:
  - state enum `sram_state_t`.
  - `SRAM_DW = 16`.
  - strobe inactive constants.
- Sub-module `sram_wait_counter`:
  - Loads WAIT−1 on state entry and counts down.
  - Outputs `last` (count == 0) and `we_window` (count != 0).
- The FSM, latches and pin registers live in the top level.

## Test plan
- **Read:** preload half-words 0x0040 = 0xBEEF and 0x0041 = 0xDEAD. Read `req_addr = 0x80` with WAIT=2 → `rsp_valid` at T+5, `rsp_rdata = 0xDEADBEEF`, `rsp_err = 0`, `we_n` never low.
- **Write then read:** write 0x12345678 to 0x100 → half-words 0x80 = 0x5678 and 0x81 = 0x1234. `we_n` is low exactly one cycle per half and high in the final cycle of each half. A read of 0x100 then returns 0x12345678.
- **Misaligned:** `req_addr = 0x102` → `rsp_err = 1` at T+1, `rsp_rdata = 0`, `ce_n` stays 1.
- **Out of range:** with SRAM_AW=18, `req_addr = 0x0008_0000` → error response at T+1.
- **Back-to-back:** `req_valid` held high for two requests → second accept at T+6, `req_ready = 0` during T+1..T+5.
- **Reset mid-write:** assert `rst` during ACC_HI → next edge all strobes inactive, `req_ready = 1`, no `rsp_valid`. A new read afterwards completes normally.
